nios2_oci_dct_packer: RTL and testbench
=======================================

# nios2_oci_dct_packer

Packs the per-instruction 2-bit compressed trace symbols produced by the Nios II OCI trace logic into 30-bit trace words. Presents the in-progress word and its fill level as `dct_buffer`/`dct_count` to the OCI test bench monitor. Hands completed words downstream to the trace FIFO over a valid/ready port. Sits between the CPU trace-symbol generator and the OCI trace FIFO, inside the `nios2_cpu_oci` hierarchy.

## Interface
Parameters:
- `SYM_W`, 2, width of one trace symbol in bits.
- `DEPTH`, 15, symbols per trace word; word width is `SYM_W*DEPTH` = 30.
- `CNT_W`, 4, width of fill counters; must hold `DEPTH`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `trc_on`  in  1  trace enable; symbols are ignored while low.
- `sym_valid`  in  1  a symbol is presented this cycle.
- `sym`  in  2  trace symbol (00 seq, 01 taken, 10 not-taken, 11 exception).
- `flush`  in  1  one-cycle request to emit a partial word.
- `dct_buffer`  out  30  in-progress word; symbol i occupies bits [2i+1:2i].
- `dct_count`  out  4  number of valid symbols in `dct_buffer` (0..14 at rest).
- `pkt_valid`  out  1  `pkt_data`/`pkt_count` hold a completed word.
- `pkt_ready`  in  1  downstream accepts the word when high with `pkt_valid`.
- `pkt_data`  out  30  completed word; unused symbol slots are 0.
- `pkt_count`  out  4  symbols in `pkt_data` (1..15).
- `overflow`  out  1  sticky: a completed word was dropped.
- `drop_cnt`  out  8  saturating count of dropped words (see Configuration).

## Operation
- Accept: `acc = sym_valid & trc_on`. On `acc`, the symbol is written at slot `dct_count`, and `n = dct_count + acc` is the post-write fill.
- Emit condition: `emit = (n == DEPTH) | (flush & n != 0)`. `flush` with `n == 0` does nothing.
- On emit, the word includes the current-cycle symbol. `dct_buffer` clears to 0 and `dct_count` clears to 0 in the same edge. Otherwise `dct_buffer`/`dct_count` take the written value and `n`.
- Output register free: `free = ~pkt_valid | pkt_ready`.
- On `emit & free`: load `pkt_data`/`pkt_count`, set `pkt_valid = 1`.
- On `emit & ~free`: the word is discarded and the held packet is unchanged. `overflow` sets to 1 and `drop_cnt` increments, saturating at 255. The buffer still clears.
- On `~emit & pkt_valid & pkt_ready`: clear `pkt_valid`.
- `overflow` and `drop_cnt` clear only on reset.
- Falling `trc_on` does not flush; software issues `flush`.

## Timing
- Reset values: `dct_buffer = 0`, `dct_count = 0`, `pkt_valid = 0`, `pkt_data = 0`, `pkt_count = 0`, `overflow = 0`, `drop_cnt = 0`. Reset is asynchronous assert, and reset mid-word or with a pending packet discards everything.
- Latency: the 15th symbol at edge k gives `pkt_valid` high after edge k. A `flush` at edge k gives `pkt_valid` high after edge k.
- Throughput: one symbol per cycle is sustained with `pkt_ready` held high. A back-to-back emit in the handshake cycle is accepted because `free` uses the current `pkt_ready`.
- `pkt_data`/`pkt_count` are stable while `pkt_valid & ~pkt_ready`.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `NIOS2_OCI_DCT_DROP_CNT_EN`:
  - Defined: the 8-bit saturating `drop_cnt` counter is built.
  - Undefined: `drop_cnt` is tied to 0; `overflow` behaves identically in both cases.

## Test plan
- Reset, then 15 consecutive symbols 01 with `pkt_ready = 1` -> after the 15th edge: `pkt_valid = 1`, `pkt_data = 30'h15555555`, `pkt_count = 15`, `dct_count = 0`, `dct_buffer = 0`.
- 3 symbols 11,10,01, then `flush` with no symbol -> `pkt_data = 30'h0000001B`, `pkt_count = 3`. A second `flush` at `dct_count = 0` yields no packet.
- Symbol 10 and `flush` in the same cycle at `dct_count = 2` -> `pkt_count = 3`, slot 2 = 10; the buffer is empty the next cycle.
- Hold `pkt_ready = 0` and complete two words -> the first is held unchanged, the second is dropped, `overflow = 1`, `drop_cnt = 1` (0 with the macro undefined).
- `trc_on = 0` with `sym_valid = 1` for 20 cycles -> `dct_count` stays 0 and no packet is produced.
- Assert `reset_n` low asynchronously mid-word with `dct_count = 7` and `pkt_valid = 1` -> all outputs return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit compressed trace symbols into 30-bit trace words for the OCI trace FIFO.
// Optional feature macro: NIOS2_OCI_DCT_DROP_CNT_EN builds the saturating drop counter.
module nios2_oci_dct_packer #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 15,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   trc_on,
   input  logic                   sym_valid,
   input  logic [SYM_W-1:0]       sym,
   input  logic                   flush,
   output logic [SYM_W*DEPTH-1:0] dct_buffer,
   output logic [CNT_W-1:0]       dct_count,
   output logic                   pkt_valid,
   input  logic                   pkt_ready,
   output logic [SYM_W*DEPTH-1:0] pkt_data,
   output logic [CNT_W-1:0]       pkt_count,
   output logic                   overflow,
   output logic [7:0]             drop_cnt
);

   localparam int WORD_W = SYM_W * DEPTH;

   logic [WORD_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [WORD_W-1:0] pkt_data_q, pkt_data_d;
   logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
   logic              ovf_q, ovf_d;

   logic              acc;
   logic              emit;
   logic              free;
   logic [CNT_W-1:0]  n;
   logic [WORD_W-1:0] wr_buf;

   always_comb begin
      acc    = sym_valid & trc_on;
      wr_buf = buf_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (acc && (cnt_q == CNT_W'(i))) begin
            wr_buf[i*SYM_W +: SYM_W] = sym;
         end
      end
      n    = cnt_q + CNT_W'(acc);
      // The emitted word already contains this cycle's symbol.
      emit = (n == CNT_W'(DEPTH)) | (flush & (n != '0));
      free = ~pkt_valid_q | pkt_ready;
   end

   always_comb begin
      buf_d       = wr_buf;
      cnt_d       = n;
      pkt_valid_d = pkt_valid_q;
      pkt_data_d  = pkt_data_q;
      pkt_count_d = pkt_count_q;
      ovf_d       = ovf_q;
      if (emit) begin
         buf_d = '0;
         cnt_d = '0;
         if (free) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = wr_buf;
            pkt_count_d = n;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (pkt_valid_q && pkt_ready) begin
         pkt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q       <= '0;
         cnt_q       <= '0;
         pkt_valid_q <= 1'b0;
         pkt_data_q  <= '0;
         pkt_count_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_data_q  <= pkt_data_d;
         pkt_count_q <= pkt_count_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (emit && !free && (drop_q != '1)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

   assign dct_buffer = buf_q;
   assign dct_count  = cnt_q;
   assign pkt_valid  = pkt_valid_q;
   assign pkt_data   = pkt_data_q;
   assign pkt_count  = pkt_count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for nios2_oci_dct_packer: a queue-based symbol model predicts packets and drops.
module tb_nios2_oci_dct_packer;
   localparam int DEPTH = 15;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trc_on, sym_valid, flush, pkt_ready;
   logic [1:0]  sym;
   logic [29:0] dct_buffer, pkt_data;
   logic [3:0]  dct_count, pkt_count;
   logic        pkt_valid, overflow;
   logic [7:0]  drop_cnt;

   nios2_oci_dct_packer #(.SYM_W(2), .DEPTH(15), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .sym_valid(sym_valid),
      .sym(sym), .flush(flush), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
      .pkt_count(pkt_count), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [29:0] data;
      int unsigned cnt;
   } pkt_t;

   int unsigned m_syms[$];
   pkt_t        exp_q[$];
   bit          m_held;
   bit          m_ovf;
   int unsigned m_drops;

   function automatic logic [29:0] pack(input int unsigned s[$]);
      logic [29:0] w = '0;
      foreach (s[i]) w = w | (30'(s[i]) << (2 * i));
      return w;
   endfunction

   function automatic int unsigned exp_drop();
`ifdef NIOS2_OCI_DCT_DROP_CNT_EN
      return m_drops;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advances on each active edge using the inputs the stimulus set up.
   always @(posedge clk or negedge reset_n) begin
      bit emit;
      bit hs;
      if (!reset_n) begin
         m_syms.delete();
         exp_q.delete();
         m_held  = 0;
         m_ovf   = 0;
         m_drops = 0;
      end else begin
         hs = m_held && pkt_ready;
         if (trc_on && sym_valid) m_syms.push_back(int'(sym));
         emit = (m_syms.size() == DEPTH) || (flush && m_syms.size() != 0);
         if (emit) begin
            if (!m_held || pkt_ready) begin
               exp_q.push_back('{pack(m_syms), m_syms.size()});
               m_held = 1;
            end else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end
            m_syms.delete();
         end else if (hs) begin
            m_held = 0;
         end
      end
   end

   // Monitor: compares settled outputs mid-cycle and retires packets on handshake.
   always @(negedge clk) begin
      #2;
      if (reset_n) begin
         check("dct_count", 32'(dct_count), 32'(m_syms.size()));
         check("dct_buffer", 32'(dct_buffer), 32'(pack(m_syms)));
         check("pkt_valid", 32'(pkt_valid), 32'(m_held));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), exp_drop());
         if (m_held) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               check("pkt_data", 32'(pkt_data), 32'(exp_q[0].data));
               check("pkt_count", 32'(pkt_count), exp_q[0].cnt);
               if (pkt_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input bit v, input logic [1:0] s, input bit f, input bit r, input bit t);
      @(negedge clk);
      sym_valid = v;
      sym       = s;
      flush     = f;
      pkt_ready = r;
      trc_on    = t;
   endtask

   task automatic idle(input bit r);
      cyc(0, 2'b00, 0, r, 1);
   endtask

   task automatic do_reset();
      reset_n   = 0;
      trc_on    = 0;
      sym_valid = 0;
      sym       = '0;
      flush     = 0;
      pkt_ready = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      #3;
      check("rst_dct_count", 32'(dct_count), 0);
      check("rst_pkt_valid", 32'(pkt_valid), 0);
      check("rst_pkt_data", 32'(pkt_data), 0);

      // Full word of 01 symbols
      repeat (15) cyc(1, 2'b01, 0, 1, 1);
      idle(0);
      #3;
      check("full_valid", 32'(pkt_valid), 1);
      check("full_data", 32'(pkt_data), 32'h15555555);
      check("full_count", 32'(pkt_count), 15);
      check("full_dct_count", 32'(dct_count), 0);
      check("full_dct_buffer", 32'(dct_buffer), 0);
      idle(1);

      // Partial word via flush, then an empty flush
      cyc(1, 2'b11, 0, 1, 1);
      cyc(1, 2'b10, 0, 1, 1);
      cyc(1, 2'b01, 0, 1, 1);
      cyc(0, 2'b00, 1, 0, 1);
      idle(0);
      #3;
      check("flush_data", 32'(pkt_data), 32'h0000001B);
      check("flush_count", 32'(pkt_count), 3);
      idle(1);
      cyc(0, 2'b00, 1, 1, 1);
      idle(1);
      #3;
      check("empty_flush_valid", 32'(pkt_valid), 0);

      // Symbol and flush in the same cycle
      cyc(1, 2'b00, 0, 1, 1);
      cyc(1, 2'b01, 0, 1, 1);
      cyc(1, 2'b10, 1, 1, 1);
      idle(0);
      #3;
      check("symflush_count", 32'(pkt_count), 3);
      check("symflush_slot2", 32'(pkt_data[5:4]), 32'd2);
      check("symflush_dct_count", 32'(dct_count), 0);
      idle(1);

      // Backpressure: second word dropped
      repeat (15) cyc(1, 2'b11, 0, 0, 1);
      repeat (15) cyc(1, 2'b10, 0, 0, 1);
      idle(0);
      #3;
      check("bp_held_data", 32'(pkt_data), 32'h3FFFFFFF);
      check("bp_overflow", 32'(overflow), 1);
      check("bp_drop_cnt", 32'(drop_cnt), exp_drop());
      idle(1);

      // Trace disabled
      repeat (20) cyc(1, 2'b01, 0, 1, 0);
      idle(1);
      #3;
      check("trcoff_count", 32'(dct_count), 0);
      check("trcoff_valid", 32'(pkt_valid), 0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0));
      end
      idle(1);

      // Drop counter saturation
      idle(0);
      repeat (270) cyc(1, 2'($urandom), 1, 0, 1);
      idle(0);
      #3;
      check("sat_drop_cnt", 32'(drop_cnt), exp_drop());
      idle(1);

      // Asynchronous reset mid-word with a held packet
      do_reset();
      cyc(1, 2'b01, 1, 0, 1);
      repeat (7) cyc(1, 2'b10, 0, 0, 1);
      idle(0);
      #3;
      check("pre_rst_count", 32'(dct_count), 7);
      check("pre_rst_valid", 32'(pkt_valid), 1);
      reset_n = 0;
      #1;
      check("arst_dct_buffer", 32'(dct_buffer), 0);
      check("arst_dct_count", 32'(dct_count), 0);
      check("arst_pkt_valid", 32'(pkt_valid), 0);
      check("arst_pkt_data", 32'(pkt_data), 0);
      check("arst_pkt_count", 32'(pkt_count), 0);
      check("arst_overflow", 32'(overflow), 0);
      check("arst_drop_cnt", 32'(drop_cnt), 0);
      @(negedge clk);
      reset_n = 1;
      repeat (5) idle(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
